// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared state type and stage constants for the inference sequencer
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} seq_state_t;

    localparam int MAX_STAGES = 4;
    typedef logic [$clog2(MAX_STAGES)-1:0] stage_idx_t;

    localparam int STAGE_CONV1 = 0;
    localparam int STAGE_DWCV2 = 1;
    localparam int STAGE_FC1   = 2;
    localparam int STAGE_FC2   = 3;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - frame, stage and result handshakes of the sequencer
// LAYER_SEQ_PERF_EN adds the cycles_last / stage_cycles performance outputs.
interface layer_sequencer_if #(
    parameter int NUM_STAGES = 4
`ifdef LAYER_SEQ_PERF_EN
    , parameter int TMR_W = 16
`endif
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic [IDX_W-1:0]      cur_stage;
    logic                  error;
    logic                  err_clear;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0]                      cycles_last;
    logic [NUM_STAGES-1:0][TMR_W-1:0] stage_cycles;

    modport master (
        input  in_valid, stage_done, out_ready, err_clear,
        output in_ready, stage_start, out_valid, busy, cur_stage, error,
        output cycles_last, stage_cycles
    );
    modport slave (
        output in_valid, stage_done, out_ready, err_clear,
        input  in_ready, stage_start, out_valid, busy, cur_stage, error,
        input  cycles_last, stage_cycles
    );
`else
    modport master (
        input  in_valid, stage_done, out_ready, err_clear,
        output in_ready, stage_start, out_valid, busy, cur_stage, error
    );
    modport slave (
        output in_valid, stage_done, out_ready, err_clear,
        input  in_ready, stage_start, out_valid, busy, cur_stage, error
    );
`endif

endinterface

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - busy timer for the active stage
// expired is high on the last permitted cycle (count == TIMEOUT_CYCLES-1) while enabled.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - runs conv1, dwcv2, fc1, fc2 in order per frame with a watchdog
// Optional LAYER_SEQ_PERF_EN adds frame and per-stage cycle counters.
module layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int TMR_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.master  bus
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             expired;
    logic             done_hit;
    logic             handshake;

    // The start pulse is visible during the first WAIT cycle; a done in that cycle is ignored.
    assign done_hit  = bus.stage_done[idx] && (bus.stage_start == '0);
    assign handshake = bus.out_valid && bus.out_ready;

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == START),
        .enable  (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            bus.in_ready    <= 1'b1;
            bus.stage_start <= '0;
            bus.out_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.cur_stage   <= '0;
            bus.error       <= 1'b0;
        end else begin
            bus.stage_start <= '0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        idx          <= '0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= START;
                    end
                end
                START: begin
                    bus.stage_start <= NUM_STAGES'(1) << idx;
                    bus.cur_stage   <= idx;
                    state           <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a coincident timeout
                    if (done_hit) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= START;
                        end
                    end else if (expired) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= ERR;
                    end
                end
                DONE: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        bus.out_valid <= 1'b1;
                    end
                end
                ERR: begin
                    if (bus.err_clear) begin
                        bus.error    <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0]                      run_cnt;
    logic [31:0]                      run_next;
    logic [TMR_W-1:0]                 wait_cnt;
    logic [NUM_STAGES-1:0][TMR_W-1:0] stage_acc;
    logic [NUM_STAGES-1:0][TMR_W-1:0] stage_new;

    assign run_next = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    always_comb begin
        stage_new      = stage_acc;
        stage_new[idx] = wait_cnt + 1'b1;
    end

    // run_cnt holds 1 in IDLE so the accept edge itself is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt          <= '0;
            wait_cnt         <= '0;
            stage_acc        <= '0;
            bus.cycles_last  <= '0;
            bus.stage_cycles <= '0;
        end else begin
            run_cnt <= (state == IDLE) ? 32'd1 : run_next;
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WAIT && done_hit) begin
                stage_acc <= stage_new;
                if (idx == LAST_IDX) begin
                    bus.cycles_last  <= run_next;
                    bus.stage_cycles <= stage_new;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - scoreboard bench for layer_sequencer, NUM_STAGES=4, TIMEOUT_CYCLES=16
`timescale 1ns/1ps
module tb_layer_sequencer;

    localparam int NS = 4;
    localparam int EV_START  = 0;
    localparam int EV_RESULT = 1;
    localparam int EV_ERROR  = 2;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    ev_t           exp_q[$];
    int            dly[NS];
    int            due[NS];
    logic [NS-1:0] inject = '0;
    int            inject_cyc = -1;
    logic [NS-1:0] done_v;
    logic          ov_q = 1'b0;
    logic          err_q = 1'b0;
    int            seen_stage;
    int            e;

`ifdef LAYER_SEQ_PERF_EN
    layer_sequencer_if #(.NUM_STAGES(NS), .TMR_W(16)) bus ();
`else
    layer_sequencer_if #(.NUM_STAGES(NS)) bus ();
`endif

    layer_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (16),
        .TMR_W          (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic observe(input int kind, input int data);
        ev_t x;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
            return;
        end
        x = exp_q.pop_front();
        check("event_kind", kind, x.kind);
        check("event_data", data, x.data);
        check("event_cycle", cyc, x.cyc);
    endtask

    task automatic expect_ev(input int kind, input int data, input int c);
        ev_t x;
        x.kind = kind;
        x.data = data;
        x.cyc  = c;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic accept(output int edge_cyc);
        bus.in_valid = 1'b1;
        tick();
        edge_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    int'(bus.in_ready), 1);
        check({tag, "_busy"},        int'(bus.busy), 0);
        check({tag, "_out_valid"},   int'(bus.out_valid), 0);
        check({tag, "_error"},       int'(bus.error), 0);
        check({tag, "_stage_start"}, int'(bus.stage_start), 0);
        check({tag, "_cur_stage"},   int'(bus.cur_stage), 0);
    endtask

    // Monitor: turns DUT output events into scoreboard pops and schedules stage responses.
    always @(negedge clk) begin
        if (bus.stage_start != '0) begin
            seen_stage = -1;
            for (int i = 0; i < NS; i++) if (bus.stage_start[i]) seen_stage = i;
            check("start_onehot", int'($onehot(bus.stage_start)), 1);
            observe(EV_START, seen_stage);
            for (int i = 0; i < NS; i++)
                if (bus.stage_start[i] && dly[i] >= 0) due[i] = cyc + dly[i];
        end
        if (bus.out_valid && !ov_q) observe(EV_RESULT, 0);
        if (bus.error && !err_q) observe(EV_ERROR, int'(bus.cur_stage));
        ov_q  = bus.out_valid;
        err_q = bus.error;
    end

    // Stage model: single-cycle done pulses plus injected extra bits.
    always @(posedge clk) begin
        #1;
        done_v = '0;
        for (int i = 0; i < NS; i++) if (due[i] == cyc) done_v[i] = 1'b1;
        if (inject_cyc == cyc) done_v = done_v | inject;
        bus.stage_done = done_v;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clear = 1'b0;
        for (int i = 0; i < NS; i++) begin
            dly[i] = 3;
            due[i] = -1;
        end
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal frame; err_clear outside ERR must be ignored.
        accept(e);
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        expect_ev(EV_START, 2, e + 11);
        expect_ev(EV_START, 3, e + 16);
        expect_ev(EV_RESULT, 0, e + 21);
        to_cycle(e + 3);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        to_cycle(e + 21);
        check("nom_out_valid", int'(bus.out_valid), 1);
        check("nom_in_ready_before", int'(bus.in_ready), 0);
        check("nom_busy", int'(bus.busy), 1);
        to_cycle(e + 22);
        check("nom_in_ready_after", int'(bus.in_ready), 1);
        check("nom_out_valid_drop", int'(bus.out_valid), 0);
        check("nom_busy_drop", int'(bus.busy), 0);
`ifdef LAYER_SEQ_PERF_EN
        check("perf_cycles_last", int'(bus.cycles_last), 21);
        for (int i = 0; i < NS; i++) check("perf_stage_cycles", int'(bus.stage_cycles[i]), 4);
`endif

        // Backpressure: result held for 10 cycles.
        bus.out_ready = 1'b0;
        tick();
        accept(e);
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        expect_ev(EV_START, 2, e + 11);
        expect_ev(EV_START, 3, e + 16);
        expect_ev(EV_RESULT, 0, e + 21);
        to_cycle(e + 21);
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid_held", int'(bus.out_valid), 1);
            check("bp_in_ready_low", int'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_in_ready_after", int'(bus.in_ready), 1);
        check("bp_out_valid_after", int'(bus.out_valid), 0);

        // Timeout on stage 2.
        tick();
        dly[2] = -1;
        accept(e);
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        expect_ev(EV_START, 2, e + 11);
        expect_ev(EV_ERROR, 2, e + 27);
        to_cycle(e + 26);
        check("to_error_early", int'(bus.error), 0);
        check("to_busy_early", int'(bus.busy), 1);
        to_cycle(e + 27);
        check("to_error", int'(bus.error), 1);
        check("to_busy", int'(bus.busy), 0);
        check("to_in_ready", int'(bus.in_ready), 0);
        check("to_cur_stage", int'(bus.cur_stage), 2);
        to_cycle(e + 35);
        check("to_error_sticky", int'(bus.error), 1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("to_cleared_error", int'(bus.error), 0);
        check("to_cleared_in_ready", int'(bus.in_ready), 1);
        dly[2] = 3;

        // Done coinciding with the start pulse is ignored.
        tick();
        dly[0] = 5;
        accept(e);
        inject     = 4'b0001;
        inject_cyc = e + 1;
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 8);
        expect_ev(EV_START, 2, e + 13);
        expect_ev(EV_START, 3, e + 18);
        expect_ev(EV_RESULT, 0, e + 23);
        to_cycle(e + 24);
        check("same_in_ready", int'(bus.in_ready), 1);
        dly[0] = 3;

        // Spurious done[3] during stage 1, and stage 2 done on the last timer cycle.
        tick();
        dly[2] = 15;
        accept(e);
        inject     = 4'b1000;
        inject_cyc = e + 7;
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        expect_ev(EV_START, 2, e + 11);
        expect_ev(EV_START, 3, e + 28);
        expect_ev(EV_RESULT, 0, e + 33);
        to_cycle(e + 9);
        check("spur_cur_stage", int'(bus.cur_stage), 1);
        to_cycle(e + 27);
        check("coinc_error", int'(bus.error), 0);
        check("coinc_busy", int'(bus.busy), 1);
        to_cycle(e + 34);
        check("coinc_in_ready", int'(bus.in_ready), 1);
        dly[2] = 3;

        // Reset during stage 1 WAIT, then a fresh frame.
        tick();
        dly[1] = -1;
        accept(e);
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        to_cycle(e + 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (20) tick();
        dly[1] = 3;
        accept(e);
        expect_ev(EV_START, 0, e + 1);
        expect_ev(EV_START, 1, e + 6);
        expect_ev(EV_START, 2, e + 11);
        expect_ev(EV_START, 3, e + 16);
        expect_ev(EV_RESULT, 0, e + 21);
        to_cycle(e + 22);
        check("restart_in_ready", int'(bus.in_ready), 1);

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level controller for the minimobilenet inference pipeline.
- Accepts one image-valid handshake, then starts each compute stage in order: conv1, dwcv2, fc1, fc2. It waits for each stage's done before starting the next.
- Presents a result-valid handshake downstream.
- Guards each stage with a timeout watchdog and reports a sticky error.

Parameters:
- NUM_STAGES, 4, number of sequenced datapath stages (index 0 runs first).
- TIMEOUT_CYCLES, 1024, maximum cycles a stage may stay busy before the watchdog fires; must be >= 2.
- TMR_W, 16, watchdog counter width; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; every flop is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  image buffer holds a new frame.
- in_ready  output  1  sequencer can accept a frame.
- stage_start  output  NUM_STAGES  one-hot, single-cycle start pulse to stage i.
- stage_done  input  NUM_STAGES  single-cycle completion pulse from stage i.
- out_valid  output  1  classification result is stable.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high from frame accept until the result handshake or an error.
- cur_stage  output  $clog2(NUM_STAGES)  index of the active or last stage.
- error  output  1  sticky watchdog error.
- err_clear  input  1  clears error and returns to IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all outputs 0 except in_ready=1.
  - Counters cleared.
  - Reset mid-operation aborts immediately; no start pulses are issued afterwards.
- States: IDLE, START, WAIT, DONE, ERR.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready at an edge: idx<=0, state<=START, busy<=1.
- START:
  - stage_start[idx]=1 for exactly this one cycle.
  - Timer cleared to 0; state<=WAIT.
  - cur_stage=idx.
- WAIT:
  - Timer increments each cycle.
  - stage_done[idx]=1: if idx==NUM_STAGES-1, state<=DONE; else idx<=idx+1, state<=START.
  - So a new start pulse appears 2 cycles after the done pulse.
  - Done bits for other stages are ignored.
  - A done in the same cycle as the start pulse is ignored; done is sampled from the first WAIT cycle.
  - Timer==TIMEOUT_CYCLES-1 with no done: state<=ERR, error<=1.
  - If done and timeout coincide, done wins.
- DONE:
  - out_valid=1 and held until out_ready.
  - Handshake: state<=IDLE, busy<=0, in_ready rises the next cycle.
  - out_valid must not drop without a handshake.
- ERR:
  - error=1, busy=0, in_ready=0; cur_stage holds the failing stage.
  - err_clear=1: error<=0, state<=IDLE.
  - err_clear outside ERR has no effect.
- Latency: frame accept to first start pulse = 1 cycle.
- in_ready is a registered function of state only; it never depends combinationally on in_valid.
- Throughput: one frame in flight. Back-to-back frames need a minimum 1 idle cycle between the result handshake and the next accept.

Optional Feature:
- Macro LAYER_SEQ_PERF_EN.
- Defined:
  - Adds output cycles_last [31:0].
  - Counts clk cycles from frame accept to entry into DONE, inclusive of the accept edge, saturating at 2**32-1.
  - Latched on DONE entry; reset value 0; not updated on an error.
  - Adds output stage_cycles [NUM_STAGES-1:0][TMR_W-1:0], per-stage WAIT durations of the last completed frame.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cnn_ctrl_pkg:
  - seq_state_t enum {IDLE, START, WAIT, DONE, ERR}.
  - stage_idx_t typedef.
  - Constants STAGE_CONV1=0, STAGE_DWCV2=1, STAGE_FC1=2, STAGE_FC2=3.
  - DEFAULT_TIMEOUT=1024.
- One sub-module, stage_watchdog:
  - Ports: clk, rst, clear, enable, expired.
  - Parameterised by TIMEOUT_CYCLES/TMR_W.
  - Instantiated once and cleared in START.

Test Plan (NUM_STAGES=4, TIMEOUT_CYCLES=16):
- Nominal run:
  - Stimulus: in_valid at cycle 0; each stage_done returns 3 cycles after its start.
  - Response: stage_start pulses 0,1,2,3 at cycles 1,6,11,16; out_valid at cycle 21.
  - With out_ready=1: in_ready returns at cycle 22; perf build reports cycles_last=21.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Response: out_valid held steady for all 10 cycles; in_ready stays 0 until the handshake.
- Timeout:
  - Stimulus: stage 2 never returns done.
  - Response: error=1 exactly 16 cycles after its start pulse; cur_stage=2; no stage_start[3].
  - Then err_clear → IDLE, in_ready=1.
- Spurious and boundary done:
  - Spurious: stage_done[3] pulsed while stage 1 is active → ignored, no skip.
  - Same-cycle done: done coinciding with the start pulse → ignored.
  - Coincident timeout: done on timer=15 → proceeds with no error.
- Reset mid-frame:
  - Stimulus: rst during stage 1 WAIT.
  - Response: next cycle all outputs at reset values and in_ready=1.
  - A new frame restarts at stage 0.
